// File: rtl/instruction_memory_loadable.sv
// Loadable instruction store: a registered, stallable fetch port and a
// byte-serial loader that writes little-endian words into the array at run time.
module instruction_memory_loadable #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int INIT_PATTERN = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_stall,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_fault,
    input  logic                  load_start,
    input  logic                  load_byte_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   load_count
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [BIW-1:0]      LAST_BYTE = BIW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

    state_t                state_q, state_d;
    logic [BIW-1:0]        byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_buf_q, word_buf_d;
    logic [DATA_WIDTH-1:0] word_assembled;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word [DEPTH];
    logic                  addr_in_range;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  fetch_fault_q, fetch_fault_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;

    // The array has no reset: its only initial value is the power-up image.
    // The word pointer of a load is the running word count itself.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q = (INIT_PATTERN != 0) ? DATA_WIDTH'(i) : '0;
        logic [DATA_WIDTH-1:0] word_d;

        always_comb begin
            word_d = word_q;
            if (wr_en && (count_q == (ADDR_WIDTH + 1)'(i))) begin
                word_d = word_assembled;
            end
        end

        always_ff @(posedge clock) begin
            word_q <= word_d;
        end

        assign rd_word[i] = word_q;
    end

    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        word_buf_d     = word_buf_q;
        count_d        = count_q;
        wr_en          = 1'b0;
        word_assembled = word_buf_q;
        for (int b = 0; b < BYTES; b++) begin
            if (byte_idx_q == BIW'(b)) begin
                word_assembled[8*b +: 8] = load_byte;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    byte_idx_d = '0;
                    word_buf_d = '0;
                    count_d    = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    state_d = FINISH;
                end else if (load_byte_valid) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        wr_en      = 1'b1;
                        count_d    = count_q + 1'b1;
                        byte_idx_d = '0;
                        word_buf_d = '0;
                        if (count_q == LAST_WORD) begin
                            state_d = FINISH;
                        end
                    end else begin
                        word_buf_d = word_assembled;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign addr_in_range = ({1'b0, fetch_addr} < DEPTH_W);

    // A stall freezes everything; requests during a load are refused outright.
    always_comb begin
        fetch_valid_d = fetch_valid_q;
        fetch_fault_d = fetch_fault_q;
        fetch_data_d  = fetch_data_q;
        if (!fetch_stall) begin
            if (fetch_req && !load_busy) begin
                fetch_valid_d = 1'b1;
                fetch_fault_d = !addr_in_range;
                fetch_data_d  = addr_in_range ? rd_word[fetch_addr] : '0;
            end else begin
                fetch_valid_d = 1'b0;
                fetch_fault_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            byte_idx_q    <= '0;
            word_buf_q    <= '0;
            count_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            word_buf_q    <= word_buf_d;
            count_q       <= count_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_data  = fetch_data_q;
    assign load_busy   = (state_q != IDLE);
    assign load_done   = (state_q == FINISH);
    assign load_count  = count_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Scoreboard bench for instruction_memory_loadable: a 256-word instance and
// a 200-word instance checked against a bench-side memory model.
module tb_instruction_memory_loadable;
    localparam int DW      = 32;
    localparam int AW      = 8;
    localparam int DEPTH_A = 256;
    localparam int DEPTH_B = 200;

    typedef struct {
        logic          valid;
        logic          fault;
        logic [DW-1:0] data;
    } fetch_exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    logic          fetch_req_a = 1'b0, fetch_stall_a = 1'b0;
    logic [AW-1:0] fetch_addr_a = '0;
    logic          fetch_valid_a, fetch_fault_a;
    logic [DW-1:0] fetch_data_a;
    logic          load_start_a = 1'b0, load_byte_valid_a = 1'b0;
    logic [7:0]    load_byte_a = '0;
    logic          load_busy_a, load_done_a;
    logic [AW:0]   load_count_a;

    logic          fetch_req_b = 1'b0, fetch_stall_b = 1'b0;
    logic [AW-1:0] fetch_addr_b = '0;
    logic          fetch_valid_b, fetch_fault_b;
    logic [DW-1:0] fetch_data_b;
    logic          load_start_b = 1'b0, load_byte_valid_b = 1'b0;
    logic [7:0]    load_byte_b = '0;
    logic          load_busy_b, load_done_b;
    logic [AW:0]   load_count_b;

    fetch_exp_t    sb_a[$];
    fetch_exp_t    sb_b[$];
    fetch_exp_t    last_a = '{1'b0, 1'b0, '0};
    fetch_exp_t    last_b = '{1'b0, 1'b0, '0};
    logic [DW-1:0] model_a [DEPTH_A];
    logic [DW-1:0] model_b [DEPTH_B];
    int            total = 0;
    int            bad   = 0;

    instruction_memory_loadable #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_A), .INIT_PATTERN(1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n),
        .fetch_req(fetch_req_a), .fetch_addr(fetch_addr_a), .fetch_stall(fetch_stall_a),
        .fetch_valid(fetch_valid_a), .fetch_data(fetch_data_a), .fetch_fault(fetch_fault_a),
        .load_start(load_start_a), .load_byte_valid(load_byte_valid_a), .load_byte(load_byte_a),
        .load_busy(load_busy_a), .load_done(load_done_a), .load_count(load_count_a)
    );

    instruction_memory_loadable #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_B), .INIT_PATTERN(1)
    ) dut_b (
        .clock(clock), .reset_n(reset_n),
        .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b), .fetch_stall(fetch_stall_b),
        .fetch_valid(fetch_valid_b), .fetch_data(fetch_data_b), .fetch_fault(fetch_fault_b),
        .load_start(load_start_b), .load_byte_valid(load_byte_valid_b), .load_byte(load_byte_b),
        .load_busy(load_busy_b), .load_done(load_done_b), .load_count(load_count_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one fetch cycle on instance A and queues the predicted result.
    task automatic drive_fetch_a(input logic req, input int addr, input logic busy);
        fetch_exp_t e;
        fetch_req_a  = req;
        fetch_addr_a = AW'(addr);
        if (req && !busy) begin
            if (addr >= DEPTH_A) e = '{1'b1, 1'b1, '0};
            else                 e = '{1'b1, 1'b0, model_a[addr]};
        end else begin
            e = '{1'b0, 1'b0, last_a.data};
        end
        last_a = e;
        sb_a.push_back(e);
    endtask

    task automatic drive_fetch_b(input logic req, input int addr, input logic busy);
        fetch_exp_t e;
        fetch_req_b  = req;
        fetch_addr_b = AW'(addr);
        if (req && !busy) begin
            if (addr >= DEPTH_B) e = '{1'b1, 1'b1, '0};
            else                 e = '{1'b1, 1'b0, model_b[addr]};
        end else begin
            e = '{1'b0, 1'b0, last_b.data};
        end
        last_b = e;
        sb_b.push_back(e);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        tick();
        total++;
        if ({fetch_valid_a, fetch_fault_a, load_busy_a, load_done_a} !== 4'b0 ||
            fetch_data_a !== '0 || load_count_a !== '0) begin
            bad++;
            $display("[TB] FAIL reset_a got v=%0b f=%0b busy=%0b done=%0b d=%h cnt=%0d want all zero",
                     fetch_valid_a, fetch_fault_a, load_busy_a, load_done_a, fetch_data_a, load_count_a);
        end
        total++;
        if ({fetch_valid_b, fetch_fault_b, load_busy_b, load_done_b} !== 4'b0 ||
            fetch_data_b !== '0 || load_count_b !== '0) begin
            bad++;
            $display("[TB] FAIL reset_b got v=%0b f=%0b busy=%0b done=%0b d=%h cnt=%0d want all zero",
                     fetch_valid_b, fetch_fault_b, load_busy_b, load_done_b, fetch_data_b, load_count_b);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int addrs[5] = '{5, 10, 255, 0, 77};
        fetch_exp_t e;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive_fetch_a(1'b1, addrs[i], 1'b0);
            else       drive_fetch_a(1'b0, 0, 1'b0);
            tick();
            e = sb_a.pop_front();
            total++;
            if ({fetch_valid_a, fetch_fault_a, fetch_data_a} !== {e.valid, e.fault, e.data}) begin
                bad++;
                $display("[TB] FAIL back_to_back[%0d] got v=%0b f=%0b d=%h want v=%0b f=%0b d=%h",
                         i, fetch_valid_a, fetch_fault_a, fetch_data_a, e.valid, e.fault, e.data);
            end
        end
    endtask

    task automatic test_stall();
        fetch_exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                drive_fetch_a(1'b1, 10, 1'b0);
            end else if (i < 4) begin
                fetch_stall_a = 1'b1;
                fetch_req_a   = 1'b1;
                fetch_addr_a  = AW'(20);
                sb_a.push_back(last_a);
            end else begin
                fetch_stall_a = 1'b0;
                drive_fetch_a(1'b1, 20, 1'b0);
            end
            tick();
            e = sb_a.pop_front();
            total++;
            if ({fetch_valid_a, fetch_fault_a, fetch_data_a} !== {e.valid, e.fault, e.data}) begin
                bad++;
                $display("[TB] FAIL stall[%0d] got v=%0b f=%0b d=%h want v=%0b f=%0b d=%h",
                         i, fetch_valid_a, fetch_fault_a, fetch_data_a, e.valid, e.fault, e.data);
            end
        end
        fetch_req_a = 1'b0;
        tick();
    endtask

    task automatic test_partial_load();
        fetch_exp_t e;
        load_start_a = 1'b1;
        tick();
        load_start_a      = 1'b0;
        load_byte_valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_byte_a = 8'(8'hAA + 8'h11 * i);
            tick();
        end
        load_byte_valid_a = 1'b0;
        load_start_a      = 1'b1;
        tick();
        load_start_a = 1'b0;
        total++;
        if ({load_done_a, load_busy_a} !== 2'b11 || load_count_a !== 9'd0) begin
            bad++;
            $display("[TB] FAIL partial_finish got done=%0b busy=%0b cnt=%0d want done=1 busy=1 cnt=0",
                     load_done_a, load_busy_a, load_count_a);
        end
        tick();
        drive_fetch_a(1'b1, 0, 1'b0);
        tick();
        fetch_req_a = 1'b0;
        e = sb_a.pop_front();
        total++;
        if ({fetch_valid_a, fetch_fault_a, fetch_data_a} !== {e.valid, e.fault, e.data}) begin
            bad++;
            $display("[TB] FAIL partial_word0 got v=%0b f=%0b d=%h want v=%0b f=%0b d=%h",
                     fetch_valid_a, fetch_fault_a, fetch_data_a, e.valid, e.fault, e.data);
        end
    endtask

    task automatic test_reset_mid_load();
        fetch_exp_t e;
        load_start_a = 1'b1;
        tick();
        load_start_a      = 1'b0;
        load_byte_valid_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load_byte_a = 8'(8'h11 * (i + 1));
            tick();
        end
        load_byte_valid_a = 1'b0;
        model_a[0] = 32'h44332211;
        total++;
        if (load_busy_a !== 1'b1 || load_count_a !== 9'd1) begin
            bad++;
            $display("[TB] FAIL midload_state got busy=%0b cnt=%0d want busy=1 cnt=1",
                     load_busy_a, load_count_a);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({fetch_valid_a, fetch_fault_a, load_busy_a, load_done_a} !== 4'b0 ||
            fetch_data_a !== '0 || load_count_a !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset got v=%0b f=%0b busy=%0b done=%0b d=%h cnt=%0d want all zero",
                     fetch_valid_a, fetch_fault_a, load_busy_a, load_done_a, fetch_data_a, load_count_a);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        last_a = '{1'b0, 1'b0, '0};
        last_b = '{1'b0, 1'b0, '0};
        for (int i = 0; i < 2; i++) begin
            drive_fetch_a(1'b1, i, 1'b0);
            tick();
            e = sb_a.pop_front();
            total++;
            if ({fetch_valid_a, fetch_fault_a, fetch_data_a} !== {e.valid, e.fault, e.data}) begin
                bad++;
                $display("[TB] FAIL after_reset_word%0d got v=%0b f=%0b d=%h want v=%0b f=%0b d=%h",
                         i, fetch_valid_a, fetch_fault_a, fetch_data_a, e.valid, e.fault, e.data);
            end
        end
        fetch_req_a = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        logic [7:0] bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fetch_exp_t e;
        load_start_a = 1'b1;
        drive_fetch_a(1'b1, 3, 1'b0);
        tick();
        load_start_a      = 1'b0;
        load_byte_valid_a = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e = sb_a.pop_front();
            total++;
            if ({fetch_valid_a, fetch_fault_a, fetch_data_a, load_busy_a} !==
                {e.valid, e.fault, e.data, 1'b1}) begin
                bad++;
                $display("[TB] FAIL load_fetch[%0d] got v=%0b f=%0b d=%h busy=%0b want v=%0b f=%0b d=%h busy=1",
                         i, fetch_valid_a, fetch_fault_a, fetch_data_a, load_busy_a, e.valid, e.fault, e.data);
            end
            if (i < 8) begin
                load_byte_a = bytes[i];
                drive_fetch_a(1'b1, i, 1'b1);
                tick();
            end
        end
        model_a[0] = 32'h12345678;
        model_a[1] = 32'hDEADBEEF;
        load_byte_valid_a = 1'b0;
        fetch_req_a       = 1'b0;
        load_start_a      = 1'b1;
        tick();
        load_start_a = 1'b0;
        total++;
        if ({load_done_a, load_busy_a} !== 2'b11 || load_count_a !== 9'd2) begin
            bad++;
            $display("[TB] FAIL load_finish got done=%0b busy=%0b cnt=%0d want done=1 busy=1 cnt=2",
                     load_done_a, load_busy_a, load_count_a);
        end
        tick();
        total++;
        if ({load_done_a, load_busy_a} !== 2'b00 || load_count_a !== 9'd2) begin
            bad++;
            $display("[TB] FAIL load_idle got done=%0b busy=%0b cnt=%0d want done=0 busy=0 cnt=2",
                     load_done_a, load_busy_a, load_count_a);
        end
        for (int i = 0; i < 3; i++) begin
            drive_fetch_a(1'b1, i, 1'b0);
            tick();
            e = sb_a.pop_front();
            total++;
            if ({fetch_valid_a, fetch_fault_a, fetch_data_a} !== {e.valid, e.fault, e.data}) begin
                bad++;
                $display("[TB] FAIL loaded_word%0d got v=%0b f=%0b d=%h want v=%0b f=%0b d=%h",
                         i, fetch_valid_a, fetch_fault_a, fetch_data_a, e.valid, e.fault, e.data);
            end
        end
        fetch_req_a = 1'b0;
        tick();
    endtask

    task automatic test_depth200();
        int pre_addrs[3]  = '{250, 199, 200};
        int post_addrs[5] = '{0, 1, 63, 199, 250};
        int done_seen  = 0;
        int done_cycle = -1;
        fetch_exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive_fetch_b(1'b1, pre_addrs[i], 1'b0);
            tick();
            e = sb_b.pop_front();
            total++;
            if ({fetch_valid_b, fetch_fault_b, fetch_data_b} !== {e.valid, e.fault, e.data}) begin
                bad++;
                $display("[TB] FAIL d200_pre[%0d] got v=%0b f=%0b d=%h want v=%0b f=%0b d=%h",
                         i, fetch_valid_b, fetch_fault_b, fetch_data_b, e.valid, e.fault, e.data);
            end
        end
        fetch_req_b  = 1'b0;
        load_start_b = 1'b1;
        tick();
        load_start_b      = 1'b0;
        load_byte_valid_b = 1'b1;
        for (int i = 0; i < 808; i++) begin
            load_byte_b = 8'(i);
            tick();
            if (load_done_b === 1'b1) begin
                done_seen++;
                done_cycle = i;
            end
        end
        load_byte_valid_b = 1'b0;
        for (int w = 0; w < DEPTH_B; w++) begin
            model_b[w] = {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
        end
        total++;
        if (done_seen !== 1 || done_cycle !== 799) begin
            bad++;
            $display("[TB] FAIL d200_autofinish got pulses=%0d at_byte=%0d want pulses=1 at_byte=799",
                     done_seen, done_cycle);
        end
        tick();
        total++;
        if (load_count_b !== 9'd200 || load_busy_b !== 1'b0) begin
            bad++;
            $display("[TB] FAIL d200_count got cnt=%0d busy=%0b want cnt=200 busy=0",
                     load_count_b, load_busy_b);
        end
        for (int i = 0; i < 5; i++) begin
            drive_fetch_b(1'b1, post_addrs[i], 1'b0);
            tick();
            e = sb_b.pop_front();
            total++;
            if ({fetch_valid_b, fetch_fault_b, fetch_data_b} !== {e.valid, e.fault, e.data}) begin
                bad++;
                $display("[TB] FAIL d200_post[%0d] got v=%0b f=%0b d=%h want v=%0b f=%0b d=%h",
                         i, fetch_valid_b, fetch_fault_b, fetch_data_b, e.valid, e.fault, e.data);
            end
        end
        fetch_req_b = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH_A; i++) model_a[i] = DW'(i);
        for (int i = 0; i < DEPTH_B; i++) model_b[i] = DW'(i);
        test_reset();
        test_back_to_back();
        test_stall();
        test_partial_load();
        test_reset_mid_load();
        test_full_load();
        test_depth200();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_memory_loadable.md
# instruction_memory_loadable

Parametrised instruction store for the single-cycle/pipelined core. It replaces the fixed 256x32 read-only instruction memory and serves the fetch stage with a registered, stallable read. It also provides a byte-serial program-load port, so test programs can be written at run time without re-synthesising the initial image.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word-address width.
- DEPTH, 256, number of words; must satisfy DEPTH <= 2^ADDR_WIDTH.
- INIT_PATTERN, 1, initial array image at time zero: 1 sets word i = i; 0 sets every word to 0.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  request a read of fetch_addr.
- fetch_addr  in  ADDR_WIDTH  word address to read.
- fetch_stall  in  1  freeze the fetch outputs.
- fetch_valid  out  1  fetch_data/fetch_fault hold a completed read.
- fetch_data  out  DATA_WIDTH  read data.
- fetch_fault  out  1  last read was out of range (fetch_addr >= DEPTH).
- load_start  in  1  start a load when idle; end the load when loading.
- load_byte_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte; bytes arrive little-endian within each word.
- load_busy  out  1  a load is in progress; fetches are refused.
- load_done  out  1  one-cycle pulse at the end of a load.
- load_count  out  ADDR_WIDTH+1  number of words written by the most recent load.

## Operation
- Array contents: set by INIT_PATTERN at time zero only. Reset never clears the array.
- Reset values: fetch_valid 0, fetch_data 0, fetch_fault 0, load_busy 0, load_done 0, load_count 0, FSM in IDLE.
- Fetch priority per cycle, in order:
  - fetch_stall=1: hold all fetch outputs.
  - fetch_req=1 and load_busy=0: fetch_data <= data[fetch_addr], fetch_valid <= 1, fetch_fault <= 0.
  - Out-of-range request (fetch_addr >= DEPTH): fetch_data <= 0, fetch_fault <= 1, fetch_valid <= 1.
  - Otherwise: fetch_valid <= 0, fetch_fault <= 0, fetch_data holds.
- A fetch_req while load_busy=1 is dropped; fetch_valid <= 0.
- Loader FSM, states IDLE, LOAD, FINISH:
  - IDLE -> LOAD on load_start. Clears the word pointer, the byte index and load_count. A byte presented in the same cycle is ignored.
  - LOAD, load_byte_valid=1: byte k of the current word goes to bits [8k+7:8k].
  - LOAD, word complete: on the last byte (k = DATA_WIDTH/8-1), the full word is written to data[pointer] in that same cycle. Then the pointer and load_count increment and k returns to 0.
  - LOAD -> FINISH when load_start=1. Any partial word is discarded; a byte in the same cycle is ignored.
  - LOAD -> FINISH automatically after the write to word DEPTH-1.
  - FINISH: load_done=1 for this one cycle, then -> IDLE. Bytes received in FINISH or IDLE are ignored.
- load_busy=1 in LOAD and FINISH.
- load_count holds its value until the next load_start.
- Reset mid-load: FSM returns to IDLE and the partial word is lost. Words already written keep their new values.

## Timing
- Fetch latency: 1 cycle. Request sampled at edge N; data and valid visible after edge N; a new request is accepted every cycle.
- load_busy rises on the edge that samples load_start.
- A fetch_req in the same cycle as an IDLE load_start is still served.
- A word written at edge N is readable by any fetch accepted after load_busy falls.
- load_done is asserted for exactly the one cycle the FSM is in FINISH. load_busy falls on the following edge.
- reset_n low: all outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
All scenarios use DATA_WIDTH=32 and DEPTH=256 unless stated otherwise.
- Reset, then fetch address 5 -> one cycle later fetch_valid=1, fetch_data=0x00000005, fetch_fault=0.
- Fetch address 10, then hold fetch_stall=1 for 3 cycles with fetch_addr=20 -> fetch_data stays 0x0000000A and fetch_valid stays 1. Release the stall -> 0x00000014.
- Full load sequence:
  - Stimulus: load_start; bytes 78 56 34 12 EF BE AD DE; load_start.
  - Response: one-cycle load_done pulse; load_count=2.
  - Fetch 0 -> 0x12345678; fetch 1 -> 0xDEADBEEF; fetch 2 -> 0x00000002.
  - A fetch_req issued during the load -> fetch_valid=0.
- load_start, 3 bytes, load_start -> load_count=0 and word 0 still 0x00000000.
- DEPTH=200: fetch 250 -> fetch_valid=1, fetch_fault=1, fetch_data=0. Loading 800 bytes -> auto-finish with load_count=200; extra bytes ignored.
- Assert reset_n=0 after 6 load bytes -> outputs at reset values immediately and load_busy=0. Word 0 holds the new data; word 1 still 0x00000001.
